// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and bit-reverse helper for the NTT twiddle blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ntt_pkg;

  localparam int DEF_DATA_W  = 17;
  localparam int DEF_LOG_N   = 4;
  localparam int DEF_Q       = 65537;
  localparam int DEF_PSI     = 2;
  localparam int DEF_PSI_INV = 32769;

  // Widest index the bit-reverse helper handles.
  localparam int BITREV_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    READY = 2'd2
  } state_t;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                     input int w);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/twiddle_gen_mod_mul.sv
// Combinational modular multiply: p = (a*b) mod Q, product held at full 2*DATA_W width.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b - operands below Q; p - reduced product, always below Q.
module mod_mul
  import ntt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int Q      = DEF_Q
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p
);

  localparam int PW = 2 * DATA_W;
  localparam logic [PW-1:0] QW = PW'(Q);

  logic [PW-1:0] prod;

  assign prod = PW'(a) * PW'(b);
  // The remainder is below Q < 2^DATA_W, so dropping the upper half loses nothing.
  assign p    = DATA_W'(prod % QW);

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle table generator: fills N = 2^LOG_N entries with seed^k mod Q, then serves reads.
// Latency: N cycles from the start edge to done; reads return one cycle after rd_en.
// Backpressure: start ignored while generating; reads outside READY are dropped (rd_valid low).
// Ports: clk/rst (async active-high); start/inv request a table (inv picks PSI_INV);
//        busy/done/mode report status; rd_en/rd_addr -> rd_data/rd_valid is the read port.
// Build option TWIDDLE_BITREV_EN: reads return entry bitrev(rd_addr) instead of rd_addr.
module twiddle_gen
  import ntt_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LOG_N   = DEF_LOG_N,
  parameter int Q       = DEF_Q,
  parameter int PSI     = DEF_PSI,
  parameter int PSI_INV = DEF_PSI_INV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inv,
  output logic              busy,
  output logic              done,
  output logic              mode,
  input  logic              rd_en,
  input  logic [LOG_N-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int N = 1 << LOG_N;
  localparam logic [DATA_W-1:0] SEED_FWD = DATA_W'(PSI);
  localparam logic [DATA_W-1:0] SEED_INV = DATA_W'(PSI_INV);
  localparam logic [LOG_N-1:0]  K_LAST   = LOG_N'(N - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, acc_mul, seed;
  logic [LOG_N-1:0]  k, raddr;
  logic              gen_last;
  logic [DATA_W-1:0] tbl [N];

  assign seed     = mode ? SEED_INV : SEED_FWD;
  assign gen_last = (k == K_LAST);
  assign busy     = (state == GEN);

`ifdef TWIDDLE_BITREV_EN
  assign raddr = LOG_N'(bitrev(BITREV_MAX_W'(rd_addr), LOG_N));
`else
  assign raddr = rd_addr;
`endif

  mod_mul #(
    .DATA_W (DATA_W),
    .Q      (Q)
  ) u_mul (
    .a (acc),
    .b (seed),
    .p (acc_mul)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, READY: if (start) state_nxt = GEN;
      GEN:         if (gen_last) state_nxt = READY;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      k        <= '0;
      mode     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE, READY: begin
          // A new start wins over a same-cycle read and drops the old table.
          if (start) begin
            mode <= inv;
            acc  <= DATA_W'(1);
            k    <= '0;
          end else if (state == READY && rd_en) begin
            rd_data  <= tbl[raddr];
            rd_valid <= 1'b1;
          end
        end
        GEN: begin
          acc <= acc_mul;
          k   <= k + 1'b1;
          if (gen_last) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Table storage has no reset: it is never readable until a generation completes.
  always_ff @(posedge clk) begin
    if (state == GEN) tbl[k] <= acc;
  end

endmodule

// File: doc/twiddle_gen.md
TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 17: coefficient width; Q must be below 2^DATA_W.
REQ-002 SHALL have parameter LOG_N, default 4: table depth is N = 2^LOG_N.
REQ-003 SHALL have parameter Q, default 65537: the prime modulus.
REQ-004 SHALL have parameter PSI, default 2: forward primitive 2N-th root of unity mod Q.
REQ-005 SHALL have parameter PSI_INV, default 32769: PSI^-1 mod Q.
REQ-006 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port start, input, 1: request table generation.
REQ-009 SHALL have port inv, input, 1: 0 selects PSI, 1 selects PSI_INV; sampled with start.
REQ-010 SHALL have port busy, output, 1: high while generating.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when the table becomes valid.
REQ-012 SHALL have port mode, output, 1: inv value of the currently loaded table.
REQ-013 SHALL have port rd_en, input, 1: read request.
REQ-014 SHALL have port rd_addr, input, LOG_N: read index.
REQ-015 SHALL have port rd_data, output, DATA_W: twiddle value.
REQ-016 SHALL have port rd_valid, output, 1: rd_data is valid this cycle.

Function
REQ-017 SHALL implement the FSM states IDLE, GEN and READY.
REQ-018 SHALL, on start in IDLE or READY, latch inv into mode, set acc to 1 and the counter k to 0, and enter GEN.
REQ-019 SHALL, in GEN on each edge, write acc into entry k, set acc to (acc*seed) mod Q, and increment k (seed = PSI or PSI_INV per mode).
REQ-020 SHALL, on the edge that writes k = N-1, enter READY and pulse done high for exactly the following cycle; generation therefore takes N cycles after the start edge.
REQ-021 SHALL compute the product at full 2*DATA_W width and reduce it modulo the constant Q; stored values are always below Q.
REQ-022 SHALL hold busy high throughout GEN only.
REQ-023 SHALL ignore start while in GEN.
REQ-024 SHALL, on start in READY, invalidate the table until the next done.
REQ-025 SHALL, on rd_en in READY, register rd_data at the next edge and raise rd_valid for that one cycle (read latency 1); back-to-back reads SHALL be supported every cycle.
REQ-026 SHALL, on rd_en outside READY, keep rd_valid low and hold rd_data unchanged.
REQ-027 SHALL give start precedence over a same-cycle rd_en in READY: no rd_valid results.

Reset
REQ-028 SHALL, on rst high at any time including mid-GEN, immediately set state to IDLE, busy, done, rd_valid and mode to 0, rd_data, acc and k to 0; table contents are don't-care and never readable before the next done.

Configuration
REQ-029 SHALL, with TWIDDLE_BITREV_EN defined, return entry bitrev_LOG_N(rd_addr), i.e. seed^bitrev(rd_addr).
REQ-030 SHALL, without TWIDDLE_BITREV_EN, return entry rd_addr, i.e. seed^rd_addr; generation order is identical in both builds.

Structure
REQ-031 SHALL take the default DATA_W, Q, PSI and PSI_INV constants, the FSM state typedef and the bit-reverse function from package ntt_pkg.
REQ-032 SHALL place the modular multiply in one combinational sub-module, mod_mul, parameterised by DATA_W and Q.

Verification
REQ-033 SHALL verify, with defaults and no macro: reset, then start with inv=0 -> busy for 16 cycles and a done pulse; a read of addr 5 returns 32 one cycle later with rd_valid high.
REQ-034 SHALL verify, with TWIDDLE_BITREV_EN and inv=1: addr 0 returns 1, addr 1 returns 65281, addr 2 returns 61441, addr 8 returns 32769 and addr 15 returns 65535.
REQ-035 SHALL verify: rd_en during GEN gives rd_valid 0 and rd_data unchanged; start at GEN cycle 3 is ignored and done still arrives 16 cycles after the original start.
REQ-036 SHALL verify: start with inv=1 in READY gives busy high, mode 1 and reads suppressed until the new done, after which addr 2 returns 49153 (no macro).
REQ-037 SHALL verify: rst asserted at GEN cycle 7 gives IDLE immediately, busy 0 and rd_valid 0; a subsequent read stays invalid until a fresh start completes.
REQ-038 SHALL verify: consecutive reads of addr 0 then 3 (no macro, inv=0) return 1 then 8 on back-to-back cycles.
